feistel_cipher_engine: RTL and testbench

- Iterative 32-bit Feistel block cipher that services encrypt and decrypt requests from the password-keeper control FSM.
- It is the responder to that FSM's `start`/`enc_done` handshake. It sits between the plaintext/password registers and the flash/CAM datapath.
- It processes one round per clock and supports both directions with the same hardware, using a reversed key schedule for decrypt.

---
 rtl/feistel_cipher_engine.sv | 107 ++++++++++
 tb/tb_feistel_cipher_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/feistel_cipher_engine.sv
// Iterative 32-bit Feistel cipher: one round per clock, shared hardware for
// encrypt and decrypt (decrypt walks the key schedule backwards).
module feistel_cipher_engine #(
    parameter int unsigned ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] key,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        enc_done
);

    // Counter is wide enough to hold ROUNDS so the final increment never wraps.
    localparam int unsigned CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   rnd_q;
    logic [15:0]     l_q;
    logic [15:0]     r_q;
    logic [31:0]     key_q;
    logic            mode_q;
    logic [31:0]     dataOut_q;
    logic            busy_q;
    logic            encDone_q;

    logic [CW-1:0]   keyIdx;
    logic [4:0]      rotAmt;
    logic [15:0]     roundKey;
    logic [15:0]     fOut;
    logic [15:0]     l_d;
    logic [15:0]     r_d;

    // Round key and round function for the round selected by rnd_q.
    always_comb begin
        keyIdx   = mode_q ? (LAST - rnd_q) : rnd_q;
        rotAmt   = 5'({keyIdx, 2'b00});
        roundKey = 16'((key_q << rotAmt) | (key_q >> (6'd32 - 6'(rotAmt))));
        fOut     = ({r_q[12:0], r_q[15:13]} ^ roundKey) + r_q;
        l_d      = r_q;
        r_d      = l_q ^ fOut;
    end

    // Control FSM with registered outputs; owns the L/R halves and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            dataOut_q <= '0;
            busy_q    <= 1'b0;
            encDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        l_q     <= data_in[31:16];
                        r_q     <= data_in[15:0];
                        key_q   <= key;
                        mode_q  <= mode;
                        rnd_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    rnd_q <= rnd_q + 1'b1;
                    if (rnd_q == LAST) begin
                        dataOut_q <= {r_d, l_d};
                        encDone_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    encDone_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    encDone_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign data_out = dataOut_q;
    assign busy     = busy_q;
    assign enc_done = encDone_q;

endmodule

// File: tb/tb_feistel_cipher_engine.sv
// Scoreboard bench for feistel_cipher_engine: an 8-round and a 1-round
// instance, expected results queued at issue time and checked on enc_done.
module tb_feistel_cipher_engine;

    typedef struct {
        logic [31:0] data;
        int          edgeNum;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          nCmp = 0;
    int          nBad = 0;

    logic        start8, mode8, busy8, encDone8;
    logic [31:0] key8, data8, dataOut8;
    logic        start1, mode1, busy1, encDone1;
    logic [31:0] key1, data1, dataOut1;

    expT exp8q[$];
    expT exp1q[$];

    feistel_cipher_engine #(.ROUNDS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .key(key8),
        .data_in(data8), .data_out(dataOut8), .busy(busy8), .enc_done(encDone8)
    );

    feistel_cipher_engine #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .key(key1),
        .data_in(data1), .data_out(dataOut1), .busy(busy1), .enc_done(encDone1)
    );

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cmp(input string nm, input longint act, input longint expv);
        nCmp++;
        if (act !== expv) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    // Reference cipher computed straight from the algorithm description.
    function automatic logic [31:0] model(input logic [31:0] k, input logic [31:0] d,
                                          input bit dec, input int rounds);
        int unsigned l, r, x, f, kk, idx, amt, tmp;
        l = d >> 16;
        r = d & 32'hFFFF;
        for (int i = 0; i < rounds; i++) begin
            idx = dec ? (rounds - 1 - i) : i;
            amt = (4 * idx) % 32;
            kk  = (amt == 0) ? k : ((k << amt) | (k >> (32 - amt)));
            x   = r;
            f   = (((((x << 3) | (x >> 13)) & 32'hFFFF) ^ (kk & 32'hFFFF)) + x) & 32'hFFFF;
            tmp = l;
            l   = r;
            r   = tmp ^ f;
        end
        return {r[15:0], l[15:0]};
    endfunction

    // Monitor for the 8-round instance.
    always @(negedge clk) begin
        if (!rst && encDone8) begin
            if (exp8q.size() == 0) begin
                nCmp++;
                nBad++;
                $display("[TB] FAIL dut8 enc_done: got unexpected pulse, required none (data_out=%h)", dataOut8);
            end else begin
                expT e;
                e = exp8q.pop_front();
                cmp("dut8 data_out", dataOut8, e.data);
                cmp("dut8 latency", cyc - e.edgeNum, 8);
            end
        end
    end

    // Monitor for the 1-round instance.
    always @(negedge clk) begin
        if (!rst && encDone1) begin
            if (exp1q.size() == 0) begin
                nCmp++;
                nBad++;
                $display("[TB] FAIL dut1 enc_done: got unexpected pulse, required none (data_out=%h)", dataOut1);
            end else begin
                expT e;
                e = exp1q.pop_front();
                cmp("dut1 data_out", dataOut1, e.data);
                cmp("dut1 latency", cyc - e.edgeNum, 1);
            end
        end
    end

    // Issue one request to the 8-round instance and wait for it to finish.
    task automatic applyStimulus8(input logic [31:0] k, input logic [31:0] d, input logic m,
                                  input logic [31:0] expv, input bit disturb);
        int n;
        @(negedge clk);
        key8   = k;
        data8  = d;
        mode8  = m;
        start8 = 1'b1;
        exp8q.push_back('{expv, cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            n++;
            if (disturb && n >= 2 && n <= 5) begin
                start8 = 1'b1;
                key8   = $urandom;
                data8  = $urandom;
                mode8  = ~mode8;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        cmp("dut8 busy cycles", n, 9);
    endtask

    // Issue one request to the 1-round instance and wait for it to finish.
    task automatic applyStimulus1(input logic [31:0] k, input logic [31:0] d, input logic m,
                                  input logic [31:0] expv);
        int n;
        @(negedge clk);
        key1   = k;
        data1  = d;
        mode1  = m;
        start1 = 1'b1;
        exp1q.push_back('{expv, cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        cmp("dut1 busy cycles", n, 2);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] d, input logic b, input logic e);
        cmp({tag, " data_out"}, d, 0);
        cmp({tag, " busy"}, b, 0);
        cmp({tag, " enc_done"}, e, 0);
    endtask

    initial begin
        logic [31:0] k, p, c;
        rst    = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; key8 = '0; data8 = '0;
        start1 = 1'b0; mode1 = 1'b0; key1 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset dut8", dataOut8, busy8, encDone8);
        checkOutput("reset dut1", dataOut1, busy1, encDone1);
        rst = 1'b0;
        $display("[TB] reset released");

        // All-zero request on the 8-round instance.
        applyStimulus8(32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Hand-computed single-round vectors.
        applyStimulus1(32'h0, 32'h00000001, 1'b0, 32'h00090001);
        applyStimulus1(32'h0, 32'h00090001, 1'b1, 32'h00000001);
        applyStimulus1(32'h1, 32'h00000000, 1'b0, 32'h00010000);

        // Directed round trip.
        c = model(32'h12345678, 32'hDEADBEEF, 1'b0, 8);
        applyStimulus8(32'h12345678, 32'hDEADBEEF, 1'b0, c, 1'b0);
        nCmp++;
        if (dataOut8 == 32'hDEADBEEF) begin
            nBad++;
            $display("[TB] FAIL dut8 ciphertext differs: got %h, required anything but DEADBEEF", dataOut8);
        end
        applyStimulus8(32'h12345678, c, 1'b1, 32'hDEADBEEF, 1'b0);

        // Random round trips: decrypt must restore the original plaintext.
        for (int i = 0; i < 100; i++) begin
            k = $urandom;
            p = $urandom;
            c = model(k, p, 1'b0, 8);
            applyStimulus8(k, p, 1'b0, c, 1'b0);
            applyStimulus8(k, c, 1'b1, p, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            k = $urandom;
            p = $urandom;
            c = model(k, p, 1'b0, 1);
            applyStimulus1(k, p, 1'b0, c);
            applyStimulus1(k, c, 1'b1, p);
        end

        // Inputs and start toggled mid-request must not disturb the result.
        k = $urandom;
        p = $urandom;
        applyStimulus8(k, p, 1'b0, model(k, p, 1'b0, 8), 1'b1);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a request.
        k = $urandom;
        p = $urandom;
        @(negedge clk);
        key8 = k; data8 = p; mode8 = 1'b0; start8 = 1'b1;
        exp8q.push_back('{model(k, p, 1'b0, 8), cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("async reset dut8", dataOut8, busy8, encDone8);
        exp8q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Fresh request after the abort.
        k = $urandom;
        p = $urandom;
        applyStimulus8(k, p, 1'b1, model(k, p, 1'b1, 8), 1'b0);

        repeat (5) @(negedge clk);
        cmp("dut8 pending results", exp8q.size(), 0);
        cmp("dut1 pending results", exp1q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
